// File: rtl/tcm_fetch_data_mem.sv
`default_nettype none
// =============================================================================
// tcm_fetch_data_mem : shared byte-addressed TCM, 64-bit fetch + 32-bit data
// Revision: 1.0
// =============================================================================

module tcm_fetch_data_mem_ram #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic [AW-1:0] i_fetch_idx,
  input  logic [AW-1:0] i_data_idx,
  input  logic          i_we,
  input  logic [7:0]    i_be,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_fetch_word,
  output logic [63:0]   o_data_word
);

  logic [63:0] ram [DEPTH];

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (i_we && i_be[k]) ram[i_data_idx][8*k +: 8] <= i_wdata[8*k +: 8];
    end
  end

  // Asynchronous read; the top registers the result, which gives read-first behaviour
  assign o_fetch_word = ram[i_fetch_idx];
  assign o_data_word  = ram[i_data_idx];

  task automatic write(input logic [31:0] byte_addr, input logic [7:0] data);
    ram[byte_addr[AW+2:3]][{byte_addr[2:0], 3'b000} +: 8] <= data;
  endtask

endmodule

module tcm_fetch_data_mem #(
  parameter int MEM_BYTES = 131072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_i_rd_i,
  input  logic        mem_i_flush_i,
  input  logic        mem_i_invalidate_i,
  input  logic [31:0] mem_i_pc_i,
  output logic        mem_i_accept_o,
  output logic        mem_i_valid_o,
  output logic        mem_i_error_o,
  output logic [63:0] mem_i_inst_o,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o
);

  localparam int C_BYTE_AW = $clog2(MEM_BYTES);
  localparam int C_IDX_W   = C_BYTE_AW - 3;
  localparam int C_DEPTH   = MEM_BYTES / 8;

  logic [C_IDX_W-1:0] w_fetch_idx;
  logic [C_IDX_W-1:0] w_data_idx;
  logic               w_store;
  logic               w_req;
  logic               w_we;
  logic [7:0]         w_be;
  logic [63:0]        w_fetch_word;
  logic [63:0]        w_data_word;
  logic [31:0]        w_data_half;

  logic               r_i_valid;
  logic [63:0]        r_inst;
  logic               r_d_ack;
  logic [31:0]        r_d_rdata;
  logic [10:0]        r_d_tag;

  assign w_fetch_idx = mem_i_pc_i[C_BYTE_AW-1:3];
  assign w_data_idx  = mem_d_addr_i[C_BYTE_AW-1:3];
  assign w_store     = |mem_d_wr_i;
  assign w_req       = mem_d_rd_i | w_store | mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i;
  // A store issued while reset is held is dropped
  assign w_we        = w_store & rst;
  assign w_be        = mem_d_addr_i[2] ? {mem_d_wr_i, 4'b0000} : {4'b0000, mem_d_wr_i};
  assign w_data_half = mem_d_addr_i[2] ? w_data_word[63:32] : w_data_word[31:0];

  tcm_fetch_data_mem_ram #(
    .DEPTH (C_DEPTH),
    .AW    (C_IDX_W)
  ) u_ram (
    .clk          (clk),
    .i_fetch_idx  (w_fetch_idx),
    .i_data_idx   (w_data_idx),
    .i_we         (w_we),
    .i_be         (w_be),
    .i_wdata      ({mem_d_data_wr_i, mem_d_data_wr_i}),
    .o_fetch_word (w_fetch_word),
    .o_data_word  (w_data_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_i_valid <= 1'b0;
      r_inst    <= 64'd0;
      r_d_ack   <= 1'b0;
      r_d_rdata <= 32'd0;
      r_d_tag   <= 11'd0;
    end else begin
      r_i_valid <= mem_i_rd_i;
      if (mem_i_rd_i) r_inst <= w_fetch_word;
      r_d_ack <= w_req;
      if (w_req) begin
        r_d_rdata <= w_data_half;
        r_d_tag   <= mem_d_req_tag_i;
      end
    end
  end

  assign mem_i_accept_o   = 1'b1;
  assign mem_i_error_o    = 1'b0;
  assign mem_i_valid_o    = r_i_valid;
  assign mem_i_inst_o     = r_inst;
  assign mem_d_accept_o   = 1'b1;
  assign mem_d_error_o    = 1'b0;
  assign mem_d_ack_o      = r_d_ack;
  assign mem_d_data_rd_o  = r_d_rdata;
  assign mem_d_resp_tag_o = r_d_tag;

  logic w_unused;
  assign w_unused = &{1'b0, mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                      mem_i_pc_i[31:C_BYTE_AW], mem_i_pc_i[2:0],
                      mem_d_addr_i[31:C_BYTE_AW], mem_d_addr_i[1:0]};

  task automatic write(input logic [31:0] byte_addr, input logic [7:0] data);
    u_ram.write(byte_addr, data);
  endtask

endmodule
`default_nettype wire

// File: tb/tb_tcm_fetch_data_mem.sv
`default_nettype none
// =============================================================================
// tb_tcm_fetch_data_mem : scoreboard bench with a byte-array reference model
// Revision: 1.0
// =============================================================================
module tb_tcm_fetch_data_mem;

  localparam int MEM_BYTES = 131072;
  localparam int REGION    = 1024;

  logic        clk;
  logic        rst;
  logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
  logic [31:0] mem_i_pc_i;
  logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
  logic [63:0] mem_i_inst_o;
  logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
  logic        mem_d_rd_i;
  logic [3:0]  mem_d_wr_i;
  logic        mem_d_cacheable_i;
  logic [10:0] mem_d_req_tag_i;
  logic        mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
  logic [31:0] mem_d_data_rd_o;
  logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [10:0] mem_d_resp_tag_o;

  tcm_fetch_data_mem #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .mem_i_rd_i(mem_i_rd_i), .mem_i_flush_i(mem_i_flush_i),
    .mem_i_invalidate_i(mem_i_invalidate_i), .mem_i_pc_i(mem_i_pc_i),
    .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
    .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
    .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
    .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
    .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
    .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
    .mem_d_flush_i(mem_d_flush_i), .mem_d_data_rd_o(mem_d_data_rd_o),
    .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o),
    .mem_d_error_o(mem_d_error_o), .mem_d_resp_tag_o(mem_d_resp_tag_o)
  );

  typedef struct { int cyc; logic [63:0] inst; } f_exp_t;
  typedef struct { int cyc; logic [31:0] data; logic [10:0] tag; } d_exp_t;

  f_exp_t      fq[$];
  d_exp_t      dq[$];
  logic [7:0]  mdl [REGION];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        rst_at_edge = 1'b0;
  logic [63:0] last_inst = 64'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is due and checks idle behaviour otherwise
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (!rst_at_edge) begin
        chk("rst_valid", {63'd0, mem_i_valid_o}, 64'd0);
        chk("rst_ack", {63'd0, mem_d_ack_o}, 64'd0);
        chk("rst_inst", mem_i_inst_o, 64'd0);
        chk("rst_rdata", {32'd0, mem_d_data_rd_o}, 64'd0);
        chk("rst_tag", {53'd0, mem_d_resp_tag_o}, 64'd0);
        last_inst = 64'd0;
      end else begin
        if (fq.size() > 0 && fq[0].cyc == cyc) begin
          f_exp_t fe;
          fe = fq.pop_front();
          chk("fetch_valid", {63'd0, mem_i_valid_o}, 64'd1);
          chk("fetch_inst", mem_i_inst_o, fe.inst);
          last_inst = fe.inst;
        end else begin
          chk("fetch_idle_valid", {63'd0, mem_i_valid_o}, 64'd0);
          chk("fetch_hold_inst", mem_i_inst_o, last_inst);
        end
        if (dq.size() > 0 && dq[0].cyc == cyc) begin
          d_exp_t de;
          de = dq.pop_front();
          chk("data_ack", {63'd0, mem_d_ack_o}, 64'd1);
          chk("data_rdata", {32'd0, mem_d_data_rd_o}, {32'd0, de.data});
          chk("data_tag", {53'd0, mem_d_resp_tag_o}, {53'd0, de.tag});
        end else begin
          chk("data_idle_ack", {63'd0, mem_d_ack_o}, 64'd0);
        end
      end
      chk("const_outs", {60'd0, mem_i_accept_o, mem_i_error_o, mem_d_accept_o, mem_d_error_o},
          64'b1010);
    end
  end

  // One cycle of stimulus; expected responses come from the byte-array model
  task automatic drive(input logic f_rd, input logic [31:0] pc, input logic d_rd,
                       input logic [3:0] wr, input logic [2:0] mnt, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [10:0] tag, input logic rst_v);
    int     fb, db;
    f_exp_t fe;
    d_exp_t de;
    rst = rst_v;
    mem_i_rd_i = f_rd; mem_i_pc_i = pc;
    mem_i_flush_i = 1'($urandom_range(0, 1)); mem_i_invalidate_i = 1'($urandom_range(0, 1));
    mem_d_rd_i = d_rd; mem_d_wr_i = wr; mem_d_addr_i = addr; mem_d_data_wr_i = wdata;
    mem_d_req_tag_i = tag; mem_d_cacheable_i = 1'($urandom_range(0, 1));
    mem_d_flush_i = mnt[0]; mem_d_invalidate_i = mnt[1]; mem_d_writeback_i = mnt[2];
    fb = int'(pc % MEM_BYTES) / 8 * 8;
    db = int'(addr % MEM_BYTES) / 4 * 4;
    if (rst_v && f_rd) begin
      fe.cyc = cyc + 1;
      for (int k = 0; k < 8; k++) fe.inst[8*k +: 8] = mdl[fb + k];
      fq.push_back(fe);
    end
    if (rst_v && (d_rd || wr != 4'd0 || mnt != 3'd0)) begin
      de.cyc = cyc + 1;
      de.tag = tag;
      for (int k = 0; k < 4; k++) de.data[8*k +: 8] = mdl[db + k];
      dq.push_back(de);
    end
    if (rst_v) begin
      for (int k = 0; k < 4; k++) if (wr[k]) mdl[db + k] = wdata[8*k +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 4'd0, 3'd0, 32'd0, 32'd0, 11'd0, 1'b1);
  endtask

  function automatic logic [31:0] rnd_addr(input int off);
    logic [31:0] r;
    r = $urandom();
    return (r & 32'hFFFE_0000) | 32'(off);
  endfunction

  initial begin
    logic [7:0] b;
    rst = 1'b0;
    mem_i_rd_i = 0; mem_i_flush_i = 0; mem_i_invalidate_i = 0; mem_i_pc_i = 0;
    mem_d_addr_i = 0; mem_d_data_wr_i = 0; mem_d_rd_i = 0; mem_d_wr_i = 0;
    mem_d_cacheable_i = 0; mem_d_req_tag_i = 0;
    mem_d_invalidate_i = 0; mem_d_writeback_i = 0; mem_d_flush_i = 0;

    for (int i = 0; i < REGION; i++) begin
      b = 8'($urandom());
      if (i < 8) b = (i == 0) ? 8'h13 : (i == 1) ? 8'h05 : (i == 2) ? 8'h50 : (i == 3) ? 8'h00 :
                     (i == 4) ? 8'h93 : (i == 5) ? 8'h05 : (i == 6) ? 8'h70 : 8'h00;
      if (i >= 32'h200 && i < 32'h204) b = (i == 32'h200) ? 8'h44 : (i == 32'h201) ? 8'h33 :
                                           (i == 32'h202) ? 8'h22 : 8'h11;
      if (i >= 32'h300 && i < 32'h308) b = 8'(8'h10 + (i - 32'h300));
      dut.write(32'(i), b);
      mdl[i] = b;
    end

    repeat (3) @(posedge clk);
    #1;

    drive(1'b1, 32'h8000_0000, 1'b0, 4'd0, 3'd0, 32'd0, 32'd0, 11'd0, 1'b1);
    chk("boot_fetch", mem_i_inst_o, 64'h0070_0593_0050_0513);

    drive(1'b0, 32'd0, 1'b0, 4'hF, 3'd0, 32'h8000_0104, 32'hDEAD_BEEF, 11'h2A, 1'b1);
    chk("store_tag", {53'd0, mem_d_resp_tag_o}, 64'h2A);
    chk("store_ram_hi", {32'd0, dut.u_ram.ram[14'h20][63:32]}, 64'hDEAD_BEEF);
    drive(1'b0, 32'd0, 1'b1, 4'd0, 3'd0, 32'h8000_0104, 32'd0, 11'h005, 1'b1);
    chk("load_back", {32'd0, mem_d_data_rd_o}, 64'hDEAD_BEEF);

    drive(1'b0, 32'd0, 1'b0, 4'b0001, 3'd0, 32'h8000_0200, 32'h0000_00AA, 11'h006, 1'b1);
    drive(1'b0, 32'd0, 1'b1, 4'd0, 3'd0, 32'h8000_0200, 32'd0, 11'h007, 1'b1);
    chk("byte_merge", {32'd0, mem_d_data_rd_o}, 64'h1122_33AA);

    drive(1'b1, 32'h8000_0300, 1'b0, 4'hF, 3'd0, 32'h8000_0304, 32'hCAFE_F00D, 11'h008, 1'b1);
    chk("fetch_store_old", mem_i_inst_o, 64'h1716_1514_1312_1110);
    drive(1'b1, 32'h8000_0302, 1'b0, 4'd0, 3'd0, 32'd0, 32'd0, 11'd0, 1'b1);
    chk("fetch_store_new", mem_i_inst_o, 64'hCAFE_F00D_1312_1110);

    for (int t = 1; t <= 3; t++) begin
      drive(1'b0, 32'd0, 1'b1, 4'd0, 3'd0, rnd_addr(t * 8), 32'd0, 11'(t), 1'b1);
      chk("b2b_tag", {53'd0, mem_d_resp_tag_o}, 64'(t));
    end

    drive(1'b1, 32'h8000_0000, 1'b1, 4'hF, 3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 11'h7FF, 1'b0);
    chk("rst_no_valid", {63'd0, mem_i_valid_o}, 64'd0);
    chk("rst_no_ack", {63'd0, mem_d_ack_o}, 64'd0);
    drive(1'b1, 32'h8000_0000, 1'b0, 4'd0, 3'd0, 32'd0, 32'd0, 11'd0, 1'b1);
    chk("post_rst_intact", mem_i_inst_o, 64'h0070_0593_0050_0513);

    for (int n = 0; n < 1500; n++) begin
      logic [3:0] wr;
      logic [2:0] mnt;
      int         kind;
      kind = int'($urandom_range(0, 5));
      wr   = (kind == 1 || kind == 2) ? 4'($urandom()) : 4'd0;
      mnt  = (kind == 3) ? 3'($urandom_range(1, 7)) : 3'd0;
      drive(1'($urandom_range(0, 1)), rnd_addr(int'($urandom_range(0, REGION - 1))),
            (kind == 0 || kind == 2), wr, mnt, rnd_addr(int'($urandom_range(0, REGION - 1))),
            $urandom(), 11'($urandom()), ($urandom_range(0, 149) != 0));
    end

    repeat (3) idle();
    chk("fetch_queue_drained", 64'(fq.size()), 64'd0);
    chk("data_queue_drained", 64'(dq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
